fifo_core: RTL and testbench

Synchronous single-clock FIFO storage element that sits behind the FIFO bus. It accepts write requests (`wr_en`/`wr_data`) and read requests (`rd_en`) from a bus master and returns `rd_data`. It reports occupancy through `fifo_full`, `fifo_empty` and `fifo_count`, and flags protocol violations through `wr_err`/`rd_err`. It is the responding end of the same FIFO bus that the testbench driver and monitor use.

---
 rtl/fifo_core.sv | 84 ++++++++
 tb/tb_fifo_core.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fifo_core.sv
// fifo_core: single-clock FIFO storage element with registered occupancy flags,
// registered read data and one-cycle error pulses for rejected requests.
module fifo_core #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] rd_data,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [AW:0]           fifo_count,
    output logic                  wr_err,
    output logic                  rd_err
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_ptr_nxt;
    logic [AW:0] rd_ptr_nxt;
    logic [AW:0] count_nxt;
    logic        full_nxt;
    logic        empty_nxt;
    logic        rd_ok;
    logic        wr_ok;

    // Accept/reject decisions from the registered flags, and the resulting next pointer/flag values.
    always_comb begin
        rd_ok      = rd_en && !fifo_empty;
        wr_ok      = wr_en && (!fifo_full || rd_ok);
        wr_ptr_nxt = wr_ok ? (wr_ptr + PTR_ONE) : wr_ptr;
        rd_ptr_nxt = rd_ok ? (rd_ptr + PTR_ONE) : rd_ptr;
        count_nxt  = fifo_count;
        if (wr_ok && !rd_ok) begin
            count_nxt = fifo_count + PTR_ONE;
        end else if (rd_ok && !wr_ok) begin
            count_nxt = fifo_count - PTR_ONE;
        end
        full_nxt  = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                    (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
        empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    end

    // Storage array is deliberately left out of reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointers, occupancy, flags, read data and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            rd_data    <= '0;
            wr_err     <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            fifo_count <= count_nxt;
            fifo_full  <= full_nxt;
            fifo_empty <= empty_nxt;
            wr_err     <= wr_en && !wr_ok;
            rd_err     <= rd_en && !rd_ok;
            if (rd_ok) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_fifo_core.sv
// tb_fifo_core: directed and randomized checks of fifo_core against a queue-based model.
module tb_fifo_core;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [4:0]       fifo_count;
    logic             wr_err;
    logic             rd_err;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] modelQ[$];
    logic [WIDTH-1:0] expRd;
    logic             expWrErr;
    logic             expRdErr;

    fifo_core #(
        .FIFO_WIDTH(WIDTH),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .fifo_count(fifo_count),
        .wr_err    (wr_err),
        .rd_err    (rd_err)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string step);
        checkOne({step, ":count"}, 32'(fifo_count), 32'(modelQ.size()));
        checkOne({step, ":full"},  32'(fifo_full),  32'(modelQ.size() == DEPTH));
        checkOne({step, ":empty"}, 32'(fifo_empty), 32'(modelQ.size() == 0));
        checkOne({step, ":rd_data"}, 32'(rd_data), 32'(expRd));
        checkOne({step, ":wr_err"}, 32'(wr_err), 32'(expWrErr));
        checkOne({step, ":rd_err"}, 32'(rd_err), 32'(expRdErr));
    endtask

    task automatic clearModel();
        modelQ.delete();
        expRd    = '0;
        expWrErr = 1'b0;
        expRdErr = 1'b0;
    endtask

    // One clock of stimulus; the model applies the FIFO rules to its queue, then outputs are checked #1 after the edge.
    task automatic applyStimulus(input string step, input logic w, input logic [WIDTH-1:0] d, input logic r);
        bit rdOk;
        bit wrOk;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        rdOk = r && (modelQ.size() > 0);
        wrOk = w && ((modelQ.size() < DEPTH) || rdOk);
        if (rdOk) expRd = modelQ.pop_front();
        if (wrOk) modelQ.push_back(d);
        expWrErr = w && !wrOk;
        expRdErr = r && !rdOk;
        #1;
        checkOutput(step);
    endtask

    initial begin
        int nextVal;
        int guard;
        bit w;
        bit r;

        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        rst_n   = 1'b1;
        clearModel();

        #2 rst_n = 1'b0;
        #20;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] fill and overflow");
        for (int i = 0; i < DEPTH; i++) applyStimulus("fill", 1'b1, WIDTH'(i), 1'b0);
        applyStimulus("overflow", 1'b1, 8'hAA, 1'b0);
        applyStimulus("overflow_idle", 1'b0, 8'h00, 1'b0);

        $display("[TB] drain and underflow");
        for (int i = 0; i < DEPTH; i++) applyStimulus("drain", 1'b0, 8'h00, 1'b1);
        applyStimulus("underflow", 1'b0, 8'h00, 1'b1);
        applyStimulus("underflow_idle", 1'b0, 8'h00, 1'b0);

        $display("[TB] simultaneous at boundaries");
        applyStimulus("empty_wr_rd", 1'b1, 8'h33, 1'b1);
        for (int i = 1; i < DEPTH; i++) applyStimulus("refill", 1'b1, WIDTH'(8'h40 + i), 1'b0);
        applyStimulus("full_wr_rd", 1'b1, 8'h55, 1'b1);
        for (int i = 0; i < DEPTH; i++) applyStimulus("drain2", 1'b0, 8'h00, 1'b1);

        $display("[TB] wrap-around");
        nextVal = 0;
        guard   = 0;
        while (nextVal < 40 && guard < 400) begin
            if (modelQ.size() <= 1)     w = 1'b1;
            else if (modelQ.size() < 5) w = 1'($urandom_range(0, 1));
            else                        w = 1'b0;
            r = (modelQ.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            applyStimulus("wrap", w, WIDTH'(nextVal), r);
            if (w) nextVal++;
            guard++;
        end
        checkOne("wrap_budget", 32'(nextVal), 32'd40);
        while (modelQ.size() > 0) applyStimulus("wrap_drain", 1'b0, 8'h00, 1'b1);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 7; i++) applyStimulus("pre_reset", 1'b1, WIDTH'(8'h70 + i), 1'b0);
        wr_en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        clearModel();
        checkOutput("async_reset");
        #2 rst_n = 1'b1;
        applyStimulus("read_after_reset", 1'b0, 8'h00, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus("random", 1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
